// File: rtl/fastreadout_pkg.sv
// Shared constants and types for the fast readout packetizer.
// Optional checksum word is enabled by defining FASTREADOUT_CHECKSUM_EN.
package fastreadout_pkg;

  localparam logic [7:0] HDR_WORD = 8'hA5;
  localparam int SEQ_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CHK  = 3'd4
  } pkt_state_t;

  // Width of a channel index; a single-channel frame still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fastreadout_pingpong_buf.sv
// Two-bank frame store with per-bank full flags.
// The writer fills one bank while the reader drains the other.
module fastreadout_pingpong_buf
  import fastreadout_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_full,
  input  logic              set_sel,
  input  logic              clr_full,
  input  logic              clr_sel,
  input  logic              rd_sel,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        full
);

  logic [DATA_W-1:0] bank0 [NUM_CH];
  logic [DATA_W-1:0] bank1 [NUM_CH];
  logic [1:0]        full_next;

  // Sample storage: one word written per accepted, non-dropped sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank0[i] <= {DATA_W{1'b0}};
        bank1[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      if (wr_sel) begin
        bank1[wr_idx] <= wr_data;
      end else begin
        bank0[wr_idx] <= wr_data;
      end
    end
  end

  // Full flags: set by the writer on the last sample, cleared by the reader at end of packet.
  always_comb begin
    full_next = full;
    if (set_full) begin
      full_next[set_sel] = 1'b1;
    end else begin
      full_next = full_next;
    end
    if (clr_full) begin
      full_next[clr_sel] = 1'b0;
    end else begin
      full_next = full_next;
    end
  end

  // Full flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      full <= full_next;
    end
  end

  assign rd_data = rd_sel ? bank1[rd_idx] : bank0[rd_idx];

endmodule

// File: rtl/fastreadout_packetizer.sv
// Readout packetizer: collects NUM_CH samples per frame into a ping-pong
// store and streams each frame as HEADER, SEQ, payload[, checksum].
// Define FASTREADOUT_CHECKSUM_EN to append the XOR checksum word.
module fastreadout_packetizer
  import fastreadout_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

  // Input side
  logic [IDX_W-1:0] ch_idx;
  logic [IDX_W-1:0] eff_idx;
  logic             fill_sel;
  logic             drop_mode;
  logic             accept;
  logic             frame_start;
  logic             is_last;
  logic             cur_drop;
  logic             wr_en;
  logic             set_full;

  // Output side
  pkt_state_t        state;
  pkt_state_t        state_next;
  logic [IDX_W-1:0]  pay_idx;
  logic [IDX_W-1:0]  pay_idx_next;
  logic              drain_sel;
  logic              drain_sel_next;
  logic              other_sel;
  logic [SEQ_W-1:0]  seq;
  logic [SEQ_W-1:0]  seq_next;
  logic              fire;
  logic              pkt_end;
  logic              clr_full;
  logic              out_valid_next;
  logic              out_last_next;
  logic [DATA_W-1:0] out_data_next;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        full;

`ifdef FASTREADOUT_CHECKSUM_EN
  logic [DATA_W-1:0] chk_acc;
`endif

  fastreadout_pingpong_buf #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (fill_sel),
    .wr_idx   (eff_idx),
    .wr_data  (in_data),
    .set_full (set_full),
    .set_sel  (fill_sel),
    .clr_full (clr_full),
    .clr_sel  (drain_sel),
    .rd_sel   (drain_sel_next),
    .rd_idx   (pay_idx_next),
    .rd_data  (rd_data),
    .full     (full)
  );

  // Sample qualification: index restart on sof, drop decision on the registered full flag.
  always_comb begin
    accept      = en & in_valid;
    eff_idx     = in_sof ? ZERO_IDX : ch_idx;
    frame_start = accept & (eff_idx == ZERO_IDX);
    is_last     = accept & (eff_idx == LAST_IDX);
    if (frame_start) begin
      cur_drop = full[fill_sel];
    end else begin
      cur_drop = drop_mode;
    end
    wr_en    = accept & ~cur_drop;
    set_full = is_last & ~cur_drop;
  end

  // Channel index, fill bank select, drop mode and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_idx    <= ZERO_IDX;
      fill_sel  <= 1'b0;
      drop_mode <= 1'b0;
      drop_cnt  <= {DROP_W{1'b0}};
    end else if (accept) begin
      ch_idx    <= is_last ? ZERO_IDX : (eff_idx + IDX_W'(1));
      drop_mode <= cur_drop;
      if (set_full) begin
        fill_sel <= ~fill_sel;
      end else begin
        fill_sel <= fill_sel;
      end
      if (frame_start && full[fill_sel] && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end

  assign fire      = out_valid & out_ready;
  assign other_sel = ~drain_sel;

  // Next-state logic; a word is consumed only when the sink accepts it.
  always_comb begin
    state_next     = state;
    pay_idx_next   = pay_idx;
    drain_sel_next = drain_sel;
    seq_next       = seq;
    pkt_end        = 1'b0;
    clr_full       = 1'b0;
    case (state)
      IDLE: begin
        if (full[drain_sel]) begin
          state_next = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      HDR: begin
        if (fire) begin
          state_next = SEQ;
        end else begin
          state_next = HDR;
        end
      end
      SEQ: begin
        if (fire) begin
          state_next   = PAY;
          pay_idx_next = ZERO_IDX;
        end else begin
          state_next = SEQ;
        end
      end
      PAY: begin
        if (fire) begin
          if (pay_idx == LAST_IDX) begin
`ifdef FASTREADOUT_CHECKSUM_EN
            state_next = CHK;
`else
            pkt_end = 1'b1;
`endif
          end else begin
            pay_idx_next = pay_idx + IDX_W'(1);
          end
        end else begin
          state_next = PAY;
        end
      end
      CHK: begin
`ifdef FASTREADOUT_CHECKSUM_EN
        if (fire) begin
          pkt_end = 1'b1;
        end else begin
          state_next = CHK;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (pkt_end) begin
      clr_full       = 1'b1;
      drain_sel_next = other_sel;
      seq_next       = seq + SEQ_W'(1);
      // Chain straight into the next packet when the other bank is ready.
      state_next     = full[other_sel] ? HDR : IDLE;
    end else begin
      clr_full = 1'b0;
    end
  end

  // Output word for the state being entered, so outputs are registered with the state.
  always_comb begin
    out_valid_next = (state_next != IDLE);
    out_last_next  = 1'b0;
    out_data_next  = {DATA_W{1'b0}};
    case (state_next)
      IDLE: begin
        out_data_next = {DATA_W{1'b0}};
      end
      HDR: begin
        out_data_next = DATA_W'(HDR_WORD);
      end
      SEQ: begin
        out_data_next = DATA_W'(seq_next);
      end
      PAY: begin
        out_data_next = rd_data;
`ifdef FASTREADOUT_CHECKSUM_EN
        out_last_next = 1'b0;
`else
        out_last_next = (pay_idx_next == LAST_IDX);
`endif
      end
      CHK: begin
`ifdef FASTREADOUT_CHECKSUM_EN
        out_data_next = (state == CHK) ? out_data : (chk_acc ^ out_data);
        out_last_next = 1'b1;
`else
        out_data_next = {DATA_W{1'b0}};
`endif
      end
      default: begin
        out_data_next = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pay_idx   <= ZERO_IDX;
      drain_sel <= 1'b0;
      seq       <= {SEQ_W{1'b0}};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
    end else begin
      state     <= state_next;
      pay_idx   <= pay_idx_next;
      drain_sel <= drain_sel_next;
      seq       <= seq_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      out_data  <= out_data_next;
    end
  end

`ifdef FASTREADOUT_CHECKSUM_EN
  // Running XOR of every accepted word of the current packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= {DATA_W{1'b0}};
    end else if (fire) begin
      chk_acc <= (state == HDR) ? out_data : (chk_acc ^ out_data);
    end else begin
      chk_acc <= chk_acc;
    end
  end
`endif

  assign busy = (|full) | (state != IDLE);

endmodule

// File: tb/tb_fastreadout_packetizer.sv
// Directed self-checking bench for fastreadout_packetizer (NUM_CH=4, DATA_W=8).
module tb_fastreadout_packetizer;

`ifdef FASTREADOUT_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] drop_cnt;
  logic       busy;

  int total = 0;
  int bad = 0;
  int pkt_cnt = 0;

  fastreadout_packetizer #(.NUM_CH(4), .DATA_W(8), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count completed packets as seen by the sink.
  always @(posedge clk) begin
    if (out_valid && out_ready && out_last) pkt_cnt <= pkt_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] pl);
    put(1'b1, pl[31:24]);
    put(1'b0, pl[23:16]);
    put(1'b0, pl[15:8]);
    put(1'b0, pl[7:0]);
  endtask

  // Checks a whole packet starting with the header currently on the outputs (out_ready=1).
  task automatic expect_pkt(input string tag, input logic [7:0] sq, input logic [31:0] pl);
    logic [7:0] x;
    logic [7:0] w;
    x = 8'hA5 ^ sq;
    check_val({tag, ".hdr_v"}, out_valid, 1);
    check_val({tag, ".hdr"}, out_data, 8'hA5);
    @(negedge clk);
    check_val({tag, ".seq"}, out_data, sq);
    check_val({tag, ".seq_last"}, out_last, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w = pl[31-8*i -: 8];
      x = x ^ w;
      check_val({tag, ".pay_v"}, out_valid, 1);
      check_val({tag, ".pay"}, out_data, w);
      check_val({tag, ".pay_last"}, out_last, (i == 3) && !CHK_ON);
      @(negedge clk);
    end
`ifdef FASTREADOUT_CHECKSUM_EN
    check_val({tag, ".chk"}, out_data, x);
    check_val({tag, ".chk_last"}, out_last, 1);
    @(negedge clk);
`endif
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy && !out_valid) break;
      @(negedge clk);
    end
    check_val({tag, ".drained"}, busy, 0);
  endtask

  initial begin
    logic [7:0] x2;
    int base;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check_val("rst.valid", out_valid, 0);
    check_val("rst.data", out_data, 0);
    check_val("rst.last", out_last, 0);
    check_val("rst.drop", drop_cnt, 0);
    check_val("rst.busy", busy, 0);
    rst = 1'b0;

    // 1: single frame, header one edge after the last sample
    send_frame(32'h11223344);
    check_val("t1.latency", out_valid, 0);
    @(negedge clk);
    expect_pkt("t1", 8'h00, 32'h11223344);
    check_val("t1.idle", out_valid, 0);

    // 2: backpressure held on the SEQ word
    send_frame(32'h01020304);
    @(negedge clk);
    check_val("t2.hdr", out_data, 8'hA5);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("t2.hold_v", out_valid, 1);
      check_val("t2.hold", out_data, 8'h01);
      @(negedge clk);
    end
    out_ready = 1'b1;
    x2 = 8'hA5 ^ 8'h01;
    check_val("t2.seq", out_data, 8'h01);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      x2 = x2 ^ 8'(i);
      check_val("t2.pay", out_data, i);
      check_val("t2.pay_last", out_last, (i == 4) && !CHK_ON);
      @(negedge clk);
    end
`ifdef FASTREADOUT_CHECKSUM_EN
    check_val("t2.chk", out_data, x2);
    @(negedge clk);
`endif
    check_val("t2.idle", out_valid, 0);

    // 3: three frames while stalled, third dropped, then chained packets
    out_ready = 1'b0;
    send_frame(32'hA0A1A2A3);
    send_frame(32'hB0B1B2B3);
    send_frame(32'hC0C1C2C3);
    check_val("t3.drop", drop_cnt, 1);
    check_val("t3.busy", busy, 1);
    check_val("t3.hdr_wait", out_data, 8'hA5);
    out_ready = 1'b1;
    expect_pkt("t3a", 8'h02, 32'hA0A1A2A3);
    expect_pkt("t3b", 8'h03, 32'hB0B1B2B3);
    check_val("t3.idle", out_valid, 0);

    // 4: sof restart mid-frame, not a drop
    put(1'b1, 8'h01);
    put(1'b0, 8'h02);
    send_frame(32'h05060708);
    @(negedge clk);
    expect_pkt("t4", 8'h04, 32'h05060708);
    check_val("t4.drop", drop_cnt, 1);
    check_val("t4.idle", out_valid, 0);

    // 5: reset in the middle of the payload
    send_frame(32'h090A0B0C);
    @(negedge clk);
    check_val("t5.hdr", out_data, 8'hA5);
    @(negedge clk);
    check_val("t5.seq", out_data, 8'h05);
    @(negedge clk);
    check_val("t5.pay0", out_data, 8'h09);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t5.valid", out_valid, 0);
    check_val("t5.busy", busy, 0);
    check_val("t5.drop", drop_cnt, 0);
    send_frame(32'h0D0E0F10);
    @(negedge clk);
    expect_pkt("t5", 8'h00, 32'h0D0E0F10);

    // 6a: forced drops saturate the counter
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) send_frame(32'h55AA55AA);
    check_val("t6.sat", drop_cnt, 8'hFF);
    out_ready = 1'b1;
    drain("t6a");

    // 6b: 256 clean packets after reset, the next one carries seq 00
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = pkt_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame({8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
      repeat (4) @(negedge clk);
    end
    drain("t6b");
    check_val("t6.pkts", pkt_cnt - base, 256);
    check_val("t6.nodrop", drop_cnt, 0);
    send_frame(32'h77665544);
    @(negedge clk);
    expect_pkt("t6wrap", 8'h00, 32'h77665544);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
